// File: rtl/cla_sub_serial4.sv
// ============================================================================
// Module   : cla_sub_serial4
// Brief    : Multi-cycle subtractor, diff = a - b - bin, one 4-bit CLA slice
//            per cycle, LSB first. Optional signed-overflow output is built
//            when the CLA_SUB_OVF_EN macro is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cla_sub_serial4 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef CLA_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] c_last = IDXW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_borrow;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_diff;
    logic              r_bout;

    logic [IDXW+1:0]   w_base;
    logic [3:0]        w_x;
    logic [3:0]        w_y;
    logic [3:0]        w_g;
    logic [3:0]        w_p;
    logic [4:0]        w_c;
    logic [3:0]        w_s;
    logic              w_accept;
    logic              w_last;

    assign w_base   = {r_idx, 2'b00};
    assign w_x      = r_a[w_base +: 4];
    assign w_y      = ~r_b[w_base +: 4];
    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_idx == c_last);

    // Subtraction as a + ~b + carry, where carry-in is the inverted borrow.
    assign w_g = w_x & w_y;
    assign w_p = w_x ^ w_y;

    assign w_c[0] = ~r_borrow;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign w_s = w_p ^ w_c[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_BUSY;
            S_BUSY:  if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_idx    <= '0;
        end else if (r_state == S_BUSY) begin
            r_diff[w_base +: 4] <= w_s;
            r_borrow            <= ~w_c[4];
            r_idx               <= r_idx + 1'b1;
            if (w_last) begin
                r_bout <= ~w_c[4];
            end
        end
    end

`ifdef CLA_SUB_OVF_EN
    logic r_ovf;

    // Signed overflow: operand signs differ and result sign differs from a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_BUSY) && w_last) begin
            r_ovf <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_s[3] ^ r_a[WIDTH-1]);
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_cla_sub_serial4.sv
// ============================================================================
// Module   : tb_cla_sub_serial4
// Brief    : Self-checking bench for cla_sub_serial4 against an arithmetic
//            reference model (directed corner cases plus random operands).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cla_sub_serial4;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef CLA_SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cla_sub_serial4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef CLA_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accepts one operation, checks latency, result and DONE hold, then releases it.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                          input logic tbin, input int hold);
        logic [W-1:0] e_diff;
        logic         e_bout;
        logic         e_ovf;
        int           sr;
        int           k;

        e_diff = ta - tb_b - W'(tbin);
        e_bout = (int'(ta) < (int'(tb_b) + int'(tbin)));
        sr     = int'($signed(ta)) - int'($signed(tb_b)) - int'(tbin);
        e_ovf  = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));

        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_idle", in_ready, 1);

        in_valid = 1'b1;
        a        = ta;
        b        = tb_b;
        bin      = tbin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom);
        check("in_ready_busy", in_ready, 0);

        for (int e = 1; e <= N; e++) begin
            @(posedge clk);
            #1;
            check("out_valid_latency", out_valid, (e == N) ? 1 : 0);
        end
        check("diff", diff, e_diff);
        check("bout", bout, e_bout);
`ifdef CLA_SUB_OVF_EN
        check("ovf", ovf, e_ovf);
`endif

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_diff", diff, e_diff);
            check("hold_bout", bout, e_bout);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
`ifdef CLA_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h0234, 1'b0, 0);
        run_op(16'h0000, 16'h0001, 1'b0, 0);
        run_op(16'h0005, 16'h0005, 1'b1, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
        run_op(16'hA5C3, 16'h3C5A, 1'b1, 10);
`ifdef CLA_SUB_OVF_EN
        run_op(16'h8000, 16'h0001, 1'b0, 0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
`endif

        // Reset in the middle of BUSY, after two slices have been processed.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h9876;
        b        = 16'h1111;
        bin      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_diff", diff, 0);
        check("midrst_bout", bout, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h4321, 16'h1234, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
